// File: rtl/debug_trace_buffer.sv
// Debug-bus trace capture: timestamps qualifying debug_addr/debug_word events and
// queues them in a DEPTH-entry FIFO that is drained over a valid/ready read port.
module debug_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 16
) (
  input  logic                       clock,
  input  logic                       ctrl_reset,
  input  logic [ADDR_W-1:0]          dbg_addr,
  input  logic [DATA_W-1:0]          dbg_word,
  input  logic                       arm,
  input  logic                       mode_all,
  input  logic                       mode_wrap,
  input  logic [ADDR_W-1:0]          flt_match,
  input  logic [ADDR_W-1:0]          flt_mask,
  input  logic                       clear,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [TS_W-1:0]            rd_ts,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_word,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [TS_W-1:0]            ticks
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = TS_W + ADDR_W + DATA_W;
  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [TS_W-1:0] TS_ONE = 1;

  // Read port handshake: an entry transfers on a clock edge where rd_valid and
  // rd_ready are both high; rd_* hold steady while rd_valid=1 and rd_ready=0.

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_word;
  logic              prev_valid;

  logic              filt_hit;
  logic              bus_changed;
  logic              event_hit;
  logic              empty;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              drop;
  logic [ENT_W-1:0]  new_entry;
  logic [ENT_W-1:0]  head_entry;

  always_comb begin
    filt_hit    = (dbg_addr & flt_mask) == (flt_match & flt_mask);
    bus_changed = {dbg_addr, dbg_word} != {prev_addr, prev_word};
    event_hit   = arm & filt_hit & (mode_all | ~prev_valid | bus_changed);
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    pop         = ~empty & rd_ready & ~clear;
    // A full FIFO accepts a new event only if the head leaves this cycle or wrap mode
    // sacrifices the oldest entry; otherwise the event is lost.
    drop        = event_hit & ~clear & full & ~pop;
    wr_en       = event_hit & ~clear & (~full | pop | mode_wrap);
    new_entry   = {ticks, dbg_addr, dbg_word};
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ticks <= '0;
    end else begin
      ticks <= ticks + TS_ONE;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      prev_addr  <= '0;
      prev_word  <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_addr  <= dbg_addr;
      prev_word  <= dbg_word;
      prev_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop || (drop && mode_wrap)) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the read port is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr[PTR_W-1:0]] <= new_entry;
    end
  end

  always_comb begin
    rd_valid   = ~empty;
    head_entry = rd_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;
    rd_ts      = head_entry[ENT_W-1 -: TS_W];
    rd_addr    = head_entry[DATA_W +: ADDR_W];
    rd_word    = head_entry[DATA_W-1:0];
    count      = wr_ptr - rd_ptr;
  end

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Self-checking bench for debug_trace_buffer: table vectors, hand sequences for the
// full/wrap/clear/reset corners, and a queue scoreboard checking every popped entry.
module tb_debug_trace_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 16;
  localparam int ENT_W  = TS_W + ADDR_W + DATA_W;

  logic              clock;
  logic              ctrl_reset;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_word;
  logic              arm;
  logic              mode_all;
  logic              mode_wrap;
  logic [ADDR_W-1:0] flt_match;
  logic [ADDR_W-1:0] flt_mask;
  logic              clear;
  logic              rd_ready;
  logic              rd_valid;
  logic [TS_W-1:0]   rd_ts;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic [4:0]        count;
  logic              overflow;
  logic [TS_W-1:0]   ticks;

  debug_trace_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TS_W(TS_W), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .dbg_addr(dbg_addr), .dbg_word(dbg_word),
    .arm(arm), .mode_all(mode_all), .mode_wrap(mode_wrap), .flt_match(flt_match),
    .flt_mask(flt_mask), .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_ts(rd_ts), .rd_addr(rd_addr), .rd_word(rd_word), .count(count),
    .overflow(overflow), .ticks(ticks)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total;
  int passed;

  logic [ENT_W-1:0]  exp_q[$];
  logic [TS_W-1:0]   m_ticks;
  logic [ADDR_W-1:0] m_prev_addr;
  logic [DATA_W-1:0] m_prev_word;
  logic              m_pv;
  logic              m_ovf;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    logic              arm;
    logic [ADDR_W-1:0] match;
    logic [ADDR_W-1:0] mask;
    logic              rd_ready;
    logic [4:0]        exp_count;
    logic              exp_valid;
    logic [TS_W-1:0]   exp_ts;
    logic [DATA_W-1:0] exp_word;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ticks     = '0;
    m_prev_addr = '0;
    m_prev_word = '0;
    m_pv        = 1'b0;
    m_ovf       = 1'b0;
  endtask

  task automatic check_model();
    check("sb_rd_valid", 64'(rd_valid), 64'(exp_q.size() != 0));
    check("sb_count", 64'(count), 64'(exp_q.size()));
    check("sb_overflow", 64'(overflow), 64'(m_ovf));
    check("sb_ticks", 64'(ticks), 64'(m_ticks));
    if (exp_q.size() != 0)
      check("sb_head", 64'({rd_ts, rd_addr, rd_word}), 64'(exp_q[0]));
  endtask

  // Inputs are already applied; update the model, cross one edge, compare.
  task automatic tick();
    logic             ev;
    logic             pop;
    logic             full;
    logic [ENT_W-1:0] ent;
    ev = arm && ((dbg_addr & flt_mask) == (flt_match & flt_mask)) &&
         (mode_all || !m_pv || ({dbg_addr, dbg_word} != {m_prev_addr, m_prev_word}));
    ent = {m_ticks, dbg_addr, dbg_word};
    if (clear) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = (exp_q.size() != 0) && rd_ready;
      full = (exp_q.size() == DEPTH);
      if (pop) begin
        check("pop_entry", 64'({rd_ts, rd_addr, rd_word}), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (ev) begin
        if (full && !pop) begin
          m_ovf = 1'b1;
          if (mode_wrap) begin
            void'(exp_q.pop_front());
            exp_q.push_back(ent);
          end
        end else begin
          exp_q.push_back(ent);
        end
      end
    end
    m_prev_addr = dbg_addr;
    m_prev_word = dbg_word;
    m_pv        = 1'b1;
    m_ticks     = m_ticks + 16'd1;
    @(posedge clock);
    #1;
    check_model();
  endtask

  // Called just after an edge, so the pulse stays between edges.
  task automatic do_reset();
    ctrl_reset = 1'b1;
    #2;
    ctrl_reset = 1'b0;
    model_reset();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      dbg_addr = 12'($urandom_range(0, 4095));
      dbg_word = $urandom;
      tick();
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    ctrl_reset = 1'b1;
    dbg_addr = '0; dbg_word = '0; arm = 1'b0; mode_all = 1'b0; mode_wrap = 1'b0;
    flt_match = '0; flt_mask = '0; clear = 1'b0; rd_ready = 1'b0;

    vecs[0]  = '{12'h004, 32'h5,  1'b1, 12'h000, 12'h000, 1'b0, 5'd1, 1'b1, 16'd0,  32'h5};
    vecs[1]  = '{12'h004, 32'h5,  1'b1, 12'h000, 12'h000, 1'b0, 5'd1, 1'b1, 16'd0,  32'h5};
    vecs[2]  = '{12'h004, 32'h5,  1'b1, 12'h000, 12'h000, 1'b0, 5'd1, 1'b1, 16'd0,  32'h5};
    vecs[3]  = '{12'h004, 32'h5,  1'b1, 12'h000, 12'h000, 1'b0, 5'd1, 1'b1, 16'd0,  32'h5};
    vecs[4]  = '{12'h004, 32'h5,  1'b1, 12'h000, 12'h000, 1'b0, 5'd1, 1'b1, 16'd0,  32'h5};
    vecs[5]  = '{12'h004, 32'h5,  1'b1, 12'h000, 12'h000, 1'b1, 5'd0, 1'b0, 16'd0,  32'h0};
    vecs[6]  = '{12'h004, 32'h1,  1'b1, 12'h000, 12'h000, 1'b1, 5'd1, 1'b1, 16'd6,  32'h1};
    vecs[7]  = '{12'h004, 32'h2,  1'b1, 12'h000, 12'h000, 1'b1, 5'd1, 1'b1, 16'd7,  32'h2};
    vecs[8]  = '{12'h004, 32'h3,  1'b1, 12'h000, 12'h000, 1'b1, 5'd1, 1'b1, 16'd8,  32'h3};
    vecs[9]  = '{12'h004, 32'h3,  1'b1, 12'h000, 12'h000, 1'b1, 5'd0, 1'b0, 16'd0,  32'h0};
    vecs[10] = '{12'h00F, 32'h10, 1'b1, 12'h010, 12'hFFF, 1'b0, 5'd0, 1'b0, 16'd0,  32'h0};
    vecs[11] = '{12'h010, 32'h11, 1'b1, 12'h010, 12'hFFF, 1'b0, 5'd1, 1'b1, 16'd11, 32'h11};
    vecs[12] = '{12'h011, 32'h12, 1'b1, 12'h010, 12'hFFF, 1'b0, 5'd1, 1'b1, 16'd11, 32'h11};
    vecs[13] = '{12'h010, 32'h13, 1'b1, 12'h010, 12'hFFF, 1'b0, 5'd2, 1'b1, 16'd11, 32'h11};
    vecs[14] = '{12'h010, 32'h13, 1'b0, 12'h010, 12'hFFF, 1'b1, 5'd1, 1'b1, 16'd13, 32'h13};
    vecs[15] = '{12'h010, 32'h13, 1'b0, 12'h010, 12'hFFF, 1'b1, 5'd0, 1'b0, 16'd0,  32'h0};

    repeat (2) @(posedge clock);
    #1;
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_ticks", 64'(ticks), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_rd_fields", 64'({rd_ts, rd_addr, rd_word}), 64'd0);
    ctrl_reset = 1'b0;
    model_reset();

    // hold / change-only / filter vectors
    for (int i = 0; i < 16; i++) begin
      dbg_addr  = vecs[i].addr;
      dbg_word  = vecs[i].word;
      arm       = vecs[i].arm;
      flt_match = vecs[i].match;
      flt_mask  = vecs[i].mask;
      rd_ready  = vecs[i].rd_ready;
      tick();
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_ts", i), 64'(rd_ts), 64'(vecs[i].exp_ts));
        check($sformatf("vec%0d_word", i), 64'(rd_word), 64'(vecs[i].exp_word));
      end
    end

    // full, drop mode
    do_reset();
    arm = 1'b1; mode_all = 1'b1; mode_wrap = 1'b0; flt_mask = '0; rd_ready = 1'b0;
    fill(20);
    check("drop_count", 64'(count), 64'd16);
    check("drop_head_ts", 64'(rd_ts), 64'd0);
    check("drop_overflow", 64'(overflow), 64'd1);

    // full, wrap mode, then drain everything through the scoreboard
    do_reset();
    mode_wrap = 1'b1;
    fill(20);
    check("wrap_count", 64'(count), 64'd16);
    check("wrap_head_ts", 64'(rd_ts), 64'd4);
    check("wrap_overflow", 64'(overflow), 64'd1);
    arm = 1'b0; rd_ready = 1'b1;
    repeat (16) tick();
    check("drain_count", 64'(count), 64'd0);
    check("drain_valid", 64'(rd_valid), 64'd0);
    check("drain_overflow_sticky", 64'(overflow), 64'd1);

    // full with simultaneous pop, then overflow, then clear with event
    do_reset();
    arm = 1'b1; mode_all = 1'b1; mode_wrap = 1'b0; rd_ready = 1'b0;
    fill(16);
    check("full_count", 64'(count), 64'd16);
    check("full_overflow", 64'(overflow), 64'd0);
    rd_ready = 1'b1;
    fill(1);
    check("pushpop_count", 64'(count), 64'd16);
    check("pushpop_overflow", 64'(overflow), 64'd0);
    check("pushpop_head_ts", 64'(rd_ts), 64'd1);
    rd_ready = 1'b0;
    fill(1);
    check("lost_overflow", 64'(overflow), 64'd1);
    clear = 1'b1;
    fill(1);
    clear = 1'b0;
    check("clear_count", 64'(count), 64'd0);
    check("clear_valid", 64'(rd_valid), 64'd0);
    check("clear_overflow", 64'(overflow), 64'd0);

    // asynchronous reset between edges mid-capture
    mode_all = 1'b1; mode_wrap = 1'b1;
    fill(18);
    #2;
    ctrl_reset = 1'b1;
    #1;
    check("async_rd_valid", 64'(rd_valid), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_ticks", 64'(ticks), 64'd0);
    check("async_overflow", 64'(overflow), 64'd0);
    #1;
    ctrl_reset = 1'b0;
    model_reset();
    mode_all = 1'b0;
    dbg_addr = 12'h123; dbg_word = 32'hCAFE_0001;
    tick();
    check("post_reset_count", 64'(count), 64'd1);
    check("post_reset_ts", 64'(rd_ts), 64'd0);
    check("post_reset_word", 64'(rd_word), 64'hCAFE_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
